// File: rtl/sha256_msg_sched_if.sv
// Load/emit handshake bundle for the SHA-256 message-schedule expander.
// The slave modport is the expander; the master modport is the block source
// and the downstream round logic seen together.
interface sha256_msg_sched_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_idx;
    logic        busy;
    logic        done;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_idx,
        input  busy,
        input  done
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_idx,
        output busy,
        output done
    );
endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule expander.
// Loads 16 message words, then streams W0..W63 one word per handshake.
// Extension words are produced by a 16-word sliding window: each output
// handshake shifts the window down and appends the next W, so W[t+16] is
// ready exactly when W[t] leaves.
// Optional build macro MSG_SCHED_BSWAP_EN: byte-reverse each loaded word
// (little-endian header fields); output words stay big-endian.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_LOAD   | accepting message words M0..M15 into the window
// ST_EMIT   | presenting W[cnt] = window[0], advancing on each handshake
module sha256_msg_sched #(
    parameter int WORD_W   = 32,
    parameter int N_ROUNDS = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    sha256_msg_sched_if.slave  bus
);

    localparam logic [5:0] LAST_LOAD = 6'd15;
    localparam logic [5:0] LAST_EMIT = 6'(N_ROUNDS - 1);

    typedef enum logic {
        ST_LOAD,
        ST_EMIT
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [5:0]          cnt;
    logic [WORD_W-1:0]   w [16];
    logic [WORD_W-1:0]   w_next;
    logic [WORD_W-1:0]   in_word;
    logic                busy_q;
    logic                done_q;

    logic                in_ready_c;
    logic                out_valid_c;
    logic                load_fire;
    logic                emit_fire;
    logic                last_load;
    logic                last_emit;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

`ifdef MSG_SCHED_BSWAP_EN
    assign in_word = {bus.in_data[7:0], bus.in_data[15:8],
                      bus.in_data[23:16], bus.in_data[31:24]};
`else
    assign in_word = bus.in_data;
`endif

    // Next extension word from the current window: W[t+16] with window[0] = W[t].
    assign w_next = sig1(w[14]) + w[9] + sig0(w[1]) + w[0];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and handshake decode.
    always_comb begin
        next_state  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        load_fire   = 1'b0;
        emit_fire   = 1'b0;
        last_load   = 1'b0;
        last_emit   = 1'b0;
        case (state)
            ST_LOAD: begin
                in_ready_c = 1'b1;
                load_fire  = bus.in_valid;
                last_load  = load_fire && (cnt == LAST_LOAD);
                if (last_load) begin
                    next_state = ST_EMIT;
                end
            end
            ST_EMIT: begin
                out_valid_c = 1'b1;
                emit_fire   = bus.out_ready;
                last_emit   = emit_fire && (cnt == LAST_EMIT);
                if (last_emit) begin
                    next_state = ST_LOAD;
                end
            end
            default: begin
                next_state = ST_LOAD;
            end
        endcase
    end

    // Window, counter and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                w[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (load_fire) begin
                w[cnt[3:0]] <= in_word;
                cnt         <= last_load ? 6'd0 : cnt + 6'd1;
                busy_q      <= 1'b1;
            end
            if (emit_fire) begin
                for (int i = 0; i < 15; i++) begin
                    w[i] <= w[i+1];
                end
                w[15] <= w_next;
                cnt   <= last_emit ? 6'd0 : cnt + 6'd1;
                if (last_emit) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = (state == ST_EMIT) ? w[0] : '0;
    assign bus.out_idx   = (state == ST_EMIT) ? cnt : '0;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched.
// Expected words come from the textbook schedule recurrence over a full
// 64-entry array; honours MSG_SCHED_BSWAP_EN the same way the design does.
module tb_sha256_msg_sched;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    logic [31:0] msg   [16];
    logic [31:0] exp_w [64];
    logic [31:0] got_w [64];

    sha256_msg_sched_if bus ();

    sha256_msg_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] stored(input logic [31:0] x);
`ifdef MSG_SCHED_BSWAP_EN
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
        return x;
`endif
    endfunction

    function automatic void build_model();
        for (int t = 0; t < 16; t++) exp_w[t] = stored(msg[t]);
        for (int t = 16; t < 64; t++) begin
            exp_w[t] = (rr(exp_w[t-2], 17) ^ rr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                     + exp_w[t-7]
                     + (rr(exp_w[t-15], 7) ^ rr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                     + exp_w[t-16];
        end
    endfunction

    function automatic void set_abc();
        for (int k = 0; k < 16; k++) msg[k] = 32'h0;
`ifdef MSG_SCHED_BSWAP_EN
        msg[0] = 32'h80636261;
`else
        msg[0] = 32'h61626380;
`endif
        msg[15] = 32'h00000018;
        build_model();
    endfunction

    function automatic void set_random();
        for (int k = 0; k < 16; k++) msg[k] = $urandom;
        build_model();
    endfunction

    // Present msg[0..15]; optionally check the done pulse overlaps the first load.
    task automatic load_block(input bit chk_done);
        for (int k = 0; k < 16; k++) begin
            int waitc;
            waitc = 0;
            bus.in_valid = 1'b1;
            bus.in_data  = msg[k];
            @(negedge clk);
            while (!bus.in_ready && waitc < 200) begin
                @(posedge clk); #1;
                @(negedge clk);
                waitc++;
            end
            n_tests++;
            if (!bus.in_ready) begin
                n_fail++;
                $display("FAIL load_timeout word=%0d in_ready=%b required 1", k, bus.in_ready);
            end
            if (chk_done && k < 2) begin
                n_tests++;
                if (bus.done !== (k == 0)) begin
                    n_fail++;
                    $display("FAIL done_b2b k=%0d got=%b required=%b", k, bus.done, (k == 0));
                end
            end
            if (k > 0) begin
                n_tests++;
                if (bus.busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_load k=%0d got=%b required 1", k, bus.busy);
                end
            end
            n_tests++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL out_valid_load k=%0d got=%b required 0", k, bus.out_valid);
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    // Collect outputs until 64 handshakes (or idx reaches stop_at), checking against the model.
    task automatic emit_block(input bit rand_ready, input bit garbage, input int stop_at);
        int          idx;
        int          cyc;
        bit          prev_stall;
        logic [31:0] prev_data;
        logic [5:0]  prev_idx;
        idx = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_idx = '0;
        while (idx < 64 && cyc < 4000 && idx != stop_at) begin
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (garbage) begin
                bus.in_valid = 1'b1;
                bus.in_data  = $urandom;
            end
            @(negedge clk);
            if (cyc == 0) begin
                n_tests++;
                if (bus.out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL first_out_latency out_valid=%b required 1", bus.out_valid);
                end
            end
            n_tests++;
            if (bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_emit idx=%0d got=%b required 1", idx, bus.busy);
            end
            if (garbage) begin
                n_tests++;
                if (bus.in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL in_ready_emit idx=%0d got=%b required 0", idx, bus.in_ready);
                end
            end
            if (bus.out_valid === 1'b1) begin
                n_tests++;
                if (bus.out_idx !== 6'(idx) || bus.out_data !== exp_w[idx]) begin
                    n_fail++;
                    $display("FAIL word idx_got=%0d idx_req=%0d data_got=%08h data_req=%08h",
                             bus.out_idx, idx, bus.out_data, exp_w[idx]);
                end
                if (prev_stall) begin
                    n_tests++;
                    if (bus.out_data !== prev_data || bus.out_idx !== prev_idx) begin
                        n_fail++;
                        $display("FAIL stall_stable data_got=%08h data_req=%08h idx_got=%0d idx_req=%0d",
                                 bus.out_data, prev_data, bus.out_idx, prev_idx);
                    end
                end
                prev_stall = !bus.out_ready;
                prev_data  = bus.out_data;
                prev_idx   = bus.out_idx;
                if (bus.out_ready) begin
                    got_w[idx] = bus.out_data;
                    idx++;
                end
            end else begin
                n_tests++;
                n_fail++;
                $display("FAIL out_valid_emit idx=%0d got=%b required 1", idx, bus.out_valid);
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 4000) begin
            n_tests++;
            n_fail++;
            $display("FAIL emit_timeout idx=%0d required 64", idx);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    // Done pulses for exactly one cycle after the W63 handshake, with LOAD restored.
    task automatic check_done_pulse();
        @(negedge clk);
        n_tests++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_cycle done=%b busy=%b in_ready=%b out_valid=%b required 1 0 1 0",
                     bus.done, bus.busy, bus.in_ready, bus.out_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_width got=%b required 0", bus.done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 ||
            bus.out_idx !== 6'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset in_ready=%b out_valid=%b out_data=%08h out_idx=%0d busy=%b done=%b required 1 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.out_idx, bus.busy, bus.done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abc();
        set_abc();
        load_block(1'b0);
        emit_block(1'b0, 1'b0, -1);
        check_done_pulse();
        n_tests++;
        if (got_w[0] !== 32'h61626380 || got_w[15] !== 32'h00000018) begin
            n_fail++;
            $display("FAIL abc_w0_w15 got=%08h %08h required 61626380 00000018", got_w[0], got_w[15]);
        end
        n_tests++;
        if (got_w[16] !== 32'h61626380 || got_w[17] !== 32'h000F0000 || got_w[18] !== 32'h7DA86405) begin
            n_fail++;
            $display("FAIL abc_w16_18 got=%08h %08h %08h required 61626380 000f0000 7da86405",
                     got_w[16], got_w[17], got_w[18]);
        end
    endtask

    task automatic test_zero();
        for (int k = 0; k < 16; k++) msg[k] = 32'h0;
        build_model();
        load_block(1'b0);
        emit_block(1'b0, 1'b0, -1);
        check_done_pulse();
        n_tests++;
        if (got_w[63] !== 32'h0 || got_w[40] !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_block got=%08h %08h required 0", got_w[40], got_w[63]);
        end
    endtask

    task automatic test_backpressure();
        set_abc();
        load_block(1'b0);
        emit_block(1'b1, 1'b0, -1);
        check_done_pulse();
        set_random();
        load_block(1'b0);
        emit_block(1'b1, 1'b0, -1);
        check_done_pulse();
    endtask

    task automatic test_back_to_back();
        set_random();
        load_block(1'b0);
        emit_block(1'b0, 1'b1, -1);
        set_random();
        load_block(1'b1);
        emit_block(1'b1, 1'b1, -1);
        check_done_pulse();
    endtask

    task automatic test_mid_reset();
        set_abc();
        load_block(1'b0);
        emit_block(1'b0, 1'b0, 20);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_idx !== 6'd0) begin
            n_fail++;
            $display("FAIL mid_reset out_valid=%b in_ready=%b busy=%b out_idx=%0d required 0 1 0 0",
                     bus.out_valid, bus.in_ready, bus.busy, bus.out_idx);
        end
        @(posedge clk); #1;
        set_abc();
        load_block(1'b0);
        emit_block(1'b0, 1'b0, -1);
        check_done_pulse();
        n_tests++;
        if (got_w[16] !== 32'h61626380) begin
            n_fail++;
            $display("FAIL mid_reset_w16 got=%08h required 61626380", got_w[16]);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 32'h0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_abc();
        test_zero();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
